// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   Execute-stage branch resolution. Compares the prediction carried down from
//   IF with the outcome resolved in EXE, emits a registered one-cycle update
//   packet to the predictor and, on a mispredict, waits until the delay slot
//   is valid in ID before issuing a one-cycle flush and redirect to fetch.
//
//   Optional feature macro: BRU_PERF_CNT_EN adds the branch / mispredict
//   performance counters and their ports.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   exe_*_i             resolved branch from EXE (valid, pc, type, taken, target)
//   pred_*_i            prediction fields carried from IF
//   ds_valid_i          delay-slot instruction is valid in ID
//   ext_flush_i         exception/eret flush from a later stage
//   upd_*_o             one-cycle predictor update packet
//   flush_req_o         flush IF/ID instructions younger than the delay slot
//   redirect_valid_o    redirect fetch to redirect_pc_o
//   busy_o              hold EXE while the redirect is pending
//   perf_*_cnt_o        performance counters (BRU_PERF_CNT_EN only)
module branch_resolve_unit #(
   parameter int unsigned INDEX_W = 8,
   parameter int unsigned CNT_W   = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               exe_valid_i,
   input  logic [31:0]        exe_pc_i,
   input  logic [2:0]         exe_type_i,
   input  logic               exe_taken_i,
   input  logic [31:0]        exe_target_i,
   input  logic               pred_valid_i,
   input  logic               pred_hit_i,
   input  logic               pred_taken_i,
   input  logic [31:0]        pred_target_i,
   input  logic [1:0]         pred_count_i,
   input  logic [INDEX_W-1:0] pred_index_i,
   input  logic               ds_valid_i,
   input  logic               ext_flush_i,
   output logic               upd_valid_o,
   output logic [31:0]        upd_pc_o,
   output logic [31:0]        upd_target_o,
   output logic [2:0]         upd_type_o,
   output logic               upd_taken_o,
   output logic               upd_hit_o,
   output logic [1:0]         upd_count_o,
   output logic [INDEX_W-1:0] upd_index_o,
   output logic               flush_req_o,
   output logic               redirect_valid_o,
   output logic [31:0]        redirect_pc_o,
   output logic               busy_o
`ifdef BRU_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]   perf_br_cnt_o,
   output logic [CNT_W-1:0]   perf_mis_cnt_o
`endif
);

   typedef enum logic [1:0] {StIdle, StWaitDs, StFire} state_e;

   localparam logic [2:0] TypeNone = 3'd0;
   localparam logic [2:0] TypeBran = 3'd1;
   localparam logic [2:0] TypeRetn = 3'd4;

   state_e      state_q;
   logic [31:0] redir_q;

   logic [2:0]  type_n;
   logic        act_taken;
   logic [31:0] act_next;
   logic        eff_taken;
   logic        busy;
   logic        fire;
   logic        mispredict;
   logic        upd_send;

   // Encodings 5-7 behave exactly like "none" everywhere, including the update.
   assign type_n     = (exe_type_i > TypeRetn) ? TypeNone : exe_type_i;
   assign act_taken  = (type_n > TypeBran) | ((type_n == TypeBran) & exe_taken_i);
   assign act_next   = act_taken ? exe_target_i : (exe_pc_i + 32'd8);
   assign eff_taken  = pred_valid_i & pred_taken_i;
   assign busy       = (state_q != StIdle);
   assign fire       = exe_valid_i & ~busy & ~ext_flush_i;
   assign mispredict = fire & ((eff_taken != act_taken) |
                               (act_taken & (pred_target_i != exe_target_i)));
   // A hit on a non-branch means an aliased entry; update it so it gets retrained.
   assign upd_send   = fire & ((type_n != TypeNone) | pred_hit_i);
   assign busy_o     = busy;

   // Predictor update packet; fields hold their last value between pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         upd_valid_o  <= 1'b0;
         upd_pc_o     <= '0;
         upd_target_o <= '0;
         upd_type_o   <= '0;
         upd_taken_o  <= 1'b0;
         upd_hit_o    <= 1'b0;
         upd_count_o  <= '0;
         upd_index_o  <= '0;
      end else begin
         upd_valid_o <= upd_send;
         if (upd_send) begin
            upd_pc_o     <= exe_pc_i;
            upd_target_o <= exe_target_i;
            upd_type_o   <= type_n;
            upd_taken_o  <= act_taken;
            upd_hit_o    <= pred_hit_i & pred_valid_i;
            upd_count_o  <= pred_count_i;
            upd_index_o  <= pred_index_i;
         end
      end
   end

   // Redirect FSM; flush/redirect are registered so they coincide with StFire.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= StIdle;
         redir_q          <= '0;
         flush_req_o      <= 1'b0;
         redirect_valid_o <= 1'b0;
         redirect_pc_o    <= '0;
      end else begin
         flush_req_o      <= 1'b0;
         redirect_valid_o <= 1'b0;
         if (ext_flush_i) begin
            state_q <= StIdle;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (mispredict) begin
                     redir_q <= act_next;
                     if (ds_valid_i) begin
                        state_q          <= StFire;
                        flush_req_o      <= 1'b1;
                        redirect_valid_o <= 1'b1;
                        redirect_pc_o    <= act_next;
                     end else begin
                        state_q <= StWaitDs;
                     end
                  end
               end
               StWaitDs: begin
                  if (ds_valid_i) begin
                     state_q          <= StFire;
                     flush_req_o      <= 1'b1;
                     redirect_valid_o <= 1'b1;
                     redirect_pc_o    <= redir_q;
                  end
               end
               StFire:  state_q <= StIdle;
               default: state_q <= StIdle;
            endcase
         end
      end
   end

`ifdef BRU_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_br_cnt_o  <= '0;
         perf_mis_cnt_o <= '0;
      end else begin
         if (fire & (type_n != TypeNone)) perf_br_cnt_o  <= perf_br_cnt_o + CNT_W'(1);
         if (mispredict)                  perf_mis_cnt_o <= perf_mis_cnt_o + CNT_W'(1);
      end
   end
`else
   // Counters absent; still reject a nonsensical width at elaboration.
   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("CNT_W must be at least 1");
   end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed, table-driven bench for branch_resolve_unit plus hand-written
// sequences for the delay-slot wait, ext_flush and (optionally) counters.
module tb_branch_resolve_unit;

   logic        clk;
   logic        rst;
   logic        exe_valid;
   logic [31:0] exe_pc;
   logic [2:0]  exe_type;
   logic        exe_taken;
   logic [31:0] exe_target;
   logic        pred_valid, pred_hit, pred_taken;
   logic [31:0] pred_target;
   logic [1:0]  pred_count;
   logic [7:0]  pred_index;
   logic        ds_valid, ext_flush;
   logic        upd_valid;
   logic [31:0] upd_pc, upd_target;
   logic [2:0]  upd_type;
   logic        upd_taken, upd_hit;
   logic [1:0]  upd_count;
   logic [7:0]  upd_index;
   logic        flush_req, redirect_valid;
   logic [31:0] redirect_pc;
   logic        busy;
`ifdef BRU_PERF_CNT_EN
   logic [31:0] perf_br_cnt, perf_mis_cnt;
`endif

   branch_resolve_unit #(.INDEX_W(8), .CNT_W(32)) dut (
      .clk              (clk),
      .rst              (rst),
      .exe_valid_i      (exe_valid),
      .exe_pc_i         (exe_pc),
      .exe_type_i       (exe_type),
      .exe_taken_i      (exe_taken),
      .exe_target_i     (exe_target),
      .pred_valid_i     (pred_valid),
      .pred_hit_i       (pred_hit),
      .pred_taken_i     (pred_taken),
      .pred_target_i    (pred_target),
      .pred_count_i     (pred_count),
      .pred_index_i     (pred_index),
      .ds_valid_i       (ds_valid),
      .ext_flush_i      (ext_flush),
      .upd_valid_o      (upd_valid),
      .upd_pc_o         (upd_pc),
      .upd_target_o     (upd_target),
      .upd_type_o       (upd_type),
      .upd_taken_o      (upd_taken),
      .upd_hit_o        (upd_hit),
      .upd_count_o      (upd_count),
      .upd_index_o      (upd_index),
      .flush_req_o      (flush_req),
      .redirect_valid_o (redirect_valid),
      .redirect_pc_o    (redirect_pc),
      .busy_o           (busy)
`ifdef BRU_PERF_CNT_EN
      ,
      .perf_br_cnt_o    (perf_br_cnt),
      .perf_mis_cnt_o   (perf_mis_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  typ;
      logic        taken;
      logic [31:0] pc;
      logic [31:0] tgt;
      logic        pv, ph, pt;
      logic [31:0] ptgt;
      logic [1:0]  pcnt;
      logic [7:0]  pidx;
      logic        e_uv, e_ut, e_uh;
      logic [2:0]  e_utype;
      logic        e_mis;
      logic [31:0] e_rpc;
   } vec_t;

   vec_t vecs[11];
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv_vec(input vec_t v);
      exe_valid   = 1'b1;
      exe_pc      = v.pc;
      exe_type    = v.typ;
      exe_taken   = v.taken;
      exe_target  = v.tgt;
      pred_valid  = v.pv;
      pred_hit    = v.ph;
      pred_taken  = v.pt;
      pred_target = v.ptgt;
      pred_count  = v.pcnt;
      pred_index  = v.pidx;
      ds_valid    = 1'b1;
      ext_flush   = 1'b0;
   endtask

   task automatic idle();
      exe_valid = 1'b0;
      ds_valid  = 1'b0;
      ext_flush = 1'b0;
   endtask

   initial begin
      //          typ   tk    pc            tgt           pv ph pt ptgt         cnt   idx    uv ut uh utype mis rpc
      vecs[0]  = '{3'd1, 1'b1, 32'h0000_1000, 32'h0000_2000, 1, 1, 1, 32'h0000_2000, 2'd3, 8'h11, 1, 1, 1, 3'd1, 0, 32'h0};
      vecs[1]  = '{3'd1, 1'b0, 32'h0000_1000, 32'h0000_2000, 1, 1, 1, 32'h0000_2000, 2'd2, 8'h22, 1, 0, 1, 3'd1, 1, 32'h0000_1008};
      vecs[2]  = '{3'd4, 1'b0, 32'h0000_7000, 32'h0000_6000, 1, 1, 1, 32'h0000_5000, 2'd3, 8'h33, 1, 1, 1, 3'd4, 1, 32'h0000_6000};
      vecs[3]  = '{3'd0, 1'b1, 32'h0000_0100, 32'h0000_0000, 1, 0, 0, 32'h0000_0000, 2'd0, 8'h44, 0, 0, 0, 3'd0, 0, 32'h0};
      vecs[4]  = '{3'd0, 1'b0, 32'h0000_0100, 32'h0000_0000, 1, 1, 1, 32'h0000_1234, 2'd1, 8'h55, 1, 0, 1, 3'd0, 1, 32'h0000_0108};
      vecs[5]  = '{3'd7, 1'b1, 32'h0000_0200, 32'h0000_0300, 1, 1, 0, 32'h0000_0000, 2'd0, 8'h66, 1, 0, 1, 3'd0, 0, 32'h0};
      vecs[6]  = '{3'd1, 1'b0, 32'hFFFF_FFFC, 32'h0000_0010, 1, 1, 1, 32'h0000_0010, 2'd2, 8'h77, 1, 0, 1, 3'd1, 1, 32'h0000_0004};
      vecs[7]  = '{3'd3, 1'b0, 32'h0000_2000, 32'h0000_8000, 1, 1, 1, 32'h0000_8000, 2'd3, 8'h88, 1, 1, 1, 3'd3, 0, 32'h0};
      vecs[8]  = '{3'd1, 1'b1, 32'h0000_3000, 32'h0000_9000, 1, 1, 0, 32'h0000_0000, 2'd1, 8'h99, 1, 1, 1, 3'd1, 1, 32'h0000_9000};
      vecs[9]  = '{3'd1, 1'b0, 32'h0000_3100, 32'h0000_9000, 0, 1, 1, 32'h0000_9000, 2'd0, 8'hAA, 1, 0, 0, 3'd1, 0, 32'h0};
      vecs[10] = '{3'd2, 1'b0, 32'h0000_4000, 32'h0000_5000, 1, 1, 1, 32'h0000_5004, 2'd2, 8'hBB, 1, 1, 1, 3'd2, 1, 32'h0000_5000};

      rst = 1'b1;
      drv_vec(vecs[0]);
      idle();
      tick();
      tick();
      chk("rst upd_valid", upd_valid, 0);
      chk("rst upd_pc", upd_pc, 0);
      chk("rst flush_req", flush_req, 0);
      chk("rst redirect_valid", redirect_valid, 0);
      chk("rst redirect_pc", redirect_pc, 0);
      chk("rst busy", busy, 0);
`ifdef BRU_PERF_CNT_EN
      chk("rst perf_br", perf_br_cnt, 0);
      chk("rst perf_mis", perf_mis_cnt, 0);
`endif
      rst = 1'b0;

      // Table: each vector starts from IDLE with the delay slot present.
      for (int i = 0; i < 11; i++) begin
         drv_vec(vecs[i]);
         tick();
         chk($sformatf("v%0d upd_valid", i), upd_valid, vecs[i].e_uv);
         if (vecs[i].e_uv) begin
            chk($sformatf("v%0d upd_pc", i), upd_pc, vecs[i].pc);
            chk($sformatf("v%0d upd_target", i), upd_target, vecs[i].tgt);
            chk($sformatf("v%0d upd_type", i), upd_type, vecs[i].e_utype);
            chk($sformatf("v%0d upd_taken", i), upd_taken, vecs[i].e_ut);
            chk($sformatf("v%0d upd_hit", i), upd_hit, vecs[i].e_uh);
            chk($sformatf("v%0d upd_count", i), upd_count, vecs[i].pcnt);
            chk($sformatf("v%0d upd_index", i), upd_index, vecs[i].pidx);
         end
         chk($sformatf("v%0d flush_req", i), flush_req, vecs[i].e_mis);
         chk($sformatf("v%0d redirect_valid", i), redirect_valid, vecs[i].e_mis);
         chk($sformatf("v%0d busy", i), busy, vecs[i].e_mis);
         if (vecs[i].e_mis) chk($sformatf("v%0d redirect_pc", i), redirect_pc, vecs[i].e_rpc);
         idle();
         tick();
         chk($sformatf("v%0d idle busy", i), busy, 0);
         chk($sformatf("v%0d idle flush", i), flush_req, 0);
         chk($sformatf("v%0d idle upd_valid", i), upd_valid, 0);
      end

      // Delay slot late: jump mispredicts, ds arrives after three cycles.
      drv_vec(vecs[10]);
      exe_type = 3'd2; exe_pc = 32'h0000_3000; exe_target = 32'h0000_4000;
      pred_valid = 1'b0; pred_hit = 1'b0; pred_taken = 1'b0; pred_target = 32'h0;
      ds_valid = 1'b0;
      tick();
      chk("late busy0", busy, 1);
      chk("late upd_valid0", upd_valid, 1);
      chk("late upd_type0", upd_type, 2);
      chk("late flush0", flush_req, 0);
      drv_vec(vecs[1]);
      ds_valid = 1'b0;
      for (int k = 1; k <= 2; k++) begin
         tick();
         chk($sformatf("late busy%0d", k), busy, 1);
         chk($sformatf("late upd_valid%0d", k), upd_valid, 0);
         chk($sformatf("late flush%0d", k), redirect_valid, 0);
      end
      ds_valid = 1'b1;
      tick();
      chk("late fire flush", flush_req, 1);
      chk("late fire redirect", redirect_valid, 1);
      chk("late fire pc", redirect_pc, 32'h0000_4000);
      chk("late fire busy", busy, 1);
      chk("late fire upd_valid", upd_valid, 0);
      idle();
      tick();
      chk("late after redirect", redirect_valid, 0);
      chk("late after busy", busy, 0);

      // ext_flush in WAIT_DS cancels the redirect.
      drv_vec(vecs[1]);
      ds_valid = 1'b0;
      tick();
      chk("xf wait busy", busy, 1);
      idle();
      ds_valid  = 1'b1;
      ext_flush = 1'b1;
      tick();
      chk("xf flush", flush_req, 0);
      chk("xf redirect", redirect_valid, 0);
      chk("xf busy", busy, 0);
      // ext_flush with exe_valid suppresses both update and mispredict.
      drv_vec(vecs[1]);
      ext_flush = 1'b1;
      tick();
      chk("xf exe upd_valid", upd_valid, 0);
      chk("xf exe busy", busy, 0);
      chk("xf exe flush", flush_req, 0);
      idle();
      tick();
      chk("xf settle busy", busy, 0);

`ifdef BRU_PERF_CNT_EN
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if ((i % 3 == 0) && (i < 9)) drv_vec(vecs[1]);
         else drv_vec(vecs[0]);
         tick();
         idle();
         tick();
      end
      chk("perf br 10", perf_br_cnt, 10);
      chk("perf mis 3", perf_mis_cnt, 3);
      drv_vec(vecs[1]);
      ds_valid = 1'b0;
      tick();
      chk("perf wait busy", busy, 1);
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("perf rst br", perf_br_cnt, 0);
      chk("perf rst mis", perf_mis_cnt, 0);
      chk("perf rst busy", busy, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Execute-stage branch resolution block: the consuming end of the fetch-stage prediction. It compares the prediction carried down the pipeline with the branch outcome computed in EXE. It emits a registered one-cycle update packet to the predictor and, on a mispredict, waits for the MIPS delay slot to be captured before issuing a one-cycle flush and redirect to fetch.

## Interface
- INDEX_W, 8, width of the history index carried with each prediction
- CNT_W, 32, width of each performance counter
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high; clock clk
- exe_valid  in  1  branch-unit instruction leaves EXE this cycle
- exe_pc  in  32  PC of that instruction
- exe_type  in  3  0 none, 1 bran, 2 jump, 3 call, 4 retn; 5-7 treated as none
- exe_taken  in  1  resolved condition; ignored (forced 1) for jump/call/retn
- exe_target  in  32  resolved target
- pred_valid, pred_hit, pred_taken  in  1 each  prediction fields from IF
- pred_target  in  32  predicted next PC
- pred_count  in  2  counter value read at prediction time
- pred_index  in  INDEX_W  history index used at prediction time
- ds_valid  in  1  delay-slot instruction (exe_pc+4) is valid in ID
- ext_flush  in  1  exception/eret flush from a later stage
- upd_valid  out  1  update packet valid, one-cycle pulse
- upd_pc, upd_target  out  32 each
- upd_type  out  3;  upd_taken, upd_hit  out  1 each;  upd_count  out  2;  upd_index  out  INDEX_W
- flush_req  out  1  flush IF/ID instructions younger than the delay slot
- redirect_valid  out  1;  redirect_pc  out  32
- busy  out  1  hold EXE; FSM not in IDLE
- perf_br_cnt, perf_mis_cnt  out  CNT_W each  present only with BRU_PERF_CNT_EN

## Operation
- act_taken = (type in {jump, call, retn}) | (type==bran & exe_taken). act_next = act_taken ? exe_target : exe_pc+8.
- eff_taken = pred_valid & pred_taken.
- mispredict = fire & (eff_taken != act_taken | (act_taken & pred_target != exe_target)).
- fire = exe_valid & ~busy & ~ext_flush. exe_valid is ignored while busy.
- Update is sent when fire & (type != none | pred_hit). A type-none update overwrites an aliased entry.
- Update fields are exe_pc, exe_target, exe_type (5-7 mapped to 0), act_taken, pred_hit & pred_valid, pred_count, pred_index.
- The FSM has states IDLE, WAIT_DS and FIRE.
  - IDLE: on mispredict, latch redir = act_next. Go to FIRE if ds_valid, else go to WAIT_DS.
  - WAIT_DS: go to FIRE when ds_valid.
  - FIRE: assert flush_req and redirect_valid with redirect_pc = redir for exactly one cycle, then return to IDLE.
- busy = (state != IDLE).
- ext_flush in any state forces IDLE next cycle and suppresses flush_req/redirect_valid in that cycle. It does not cancel an update already registered.
- Reset values: all outputs 0, state IDLE, redir 0, counters 0.

## Timing
- Resolution at cycle N gives upd_valid at N+1, registered.
- Mispredict at N with ds_valid=1 at N gives flush_req/redirect_valid at N+1. busy is 1 only during N+1.
- With ds_valid=0 at N: busy from N+1. The cycle after ds_valid is first seen in WAIT_DS is FIRE.
- All 32-bit adds wrap modulo 2^32; exe_pc=0xFFFFFFFC gives fallthrough 0x00000004.
- No combinational path from inputs to any output.

## Configuration
- BRU_PERF_CNT_EN defined:
  - perf_br_cnt increments on each fire with type != none.
  - perf_mis_cnt increments on each mispredict.
  - Both wrap at 2^CNT_W and reset to 0.
- BRU_PERF_CNT_EN undefined: the counter logic and both ports are absent.

## Test plan
- Correct prediction: bran, pc 0x1000, taken, target 0x2000, pred taken, target 0x2000, ds_valid=1 -> next cycle upd_valid=1 and upd_taken=1; flush_req stays 0.
- Not-taken mispredict: bran, pc 0x1000, exe_taken=0, pred taken, ds_valid=1 -> N+1: flush_req=1, redirect_pc=0x1008, upd_taken=0; N+2: busy=0.
- Delay slot late: jump, pc 0x3000, target 0x4000, pred_hit=0, ds_valid=0 for 3 cycles then 1 -> busy high through FIRE; redirect_pc=0x4000 exactly once; exe_valid pulses while busy produce no update.
- Retn target mismatch: pred target 0x5000, exe_target 0x6000 -> mispredict, redirect_pc=0x6000, upd_type=4.
- ext_flush asserted in WAIT_DS -> no flush_req/redirect_valid; IDLE the next cycle. ext_flush together with exe_valid -> no update.
- With BRU_PERF_CNT_EN: 10 branches with 3 mispredicts -> perf_br_cnt=10, perf_mis_cnt=3; rst mid-run clears both and returns the FSM to IDLE.
